if_inst_buffer: RTL and testbench

//  Dual-issue instruction buffer between IF and the two ID decoders.

---
 rtl/if_inst_buffer.sv | 114 +++++++++++
 tb/tb_if_inst_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_inst_buffer.sv
// Dual-issue instruction buffer between IF and the two ID decoders; circular FIFO presenting head/head+1.
// Optional IBUF_PERF_EN macro adds full/empty cycle counters as extra output ports.
module if_inst_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  in_valid,
  input  logic [31:0] in_ir0,
  input  logic [31:0] in_ir1,
  input  logic [31:0] in_pc0,
  input  logic [31:0] in_pc1,
  input  logic [33:0] in_pre0,
  input  logic [33:0] in_pre1,
  output logic        in_ready,
  output logic [31:0] IF_IR0,
  output logic [31:0] IF_IR1,
  output logic [31:0] PC0,
  output logic [31:0] PC1,
  output logic [33:0] brtype_pcpre0,
  output logic [33:0] brtype_pcpre1,
  output logic [1:0]  data_valid,
`ifdef IBUF_PERF_EN
  output logic [31:0] perf_full_cyc,
  output logic [31:0] perf_empty_cyc,
`endif
  input  logic [1:0]  id_accept
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0] ir_q  [DEPTH];
  logic [31:0] pc_q  [DEPTH];
  logic [33:0] pre_q [DEPTH];
  logic [AW-1:0] wptr, rptr, wptr1, rptr1;
  logic [CW-1:0] count;
  logic [1:0]    push_n, pop_n;

  assign wptr1 = wptr + AW'(1);
  assign rptr1 = rptr + AW'(1);

  // Registered count only: a same-cycle pop does not free space for a push.
  assign in_ready = !rst && (count <= CW'(DEPTH - 2));

  always_comb begin
    push_n = 2'd0;
    if (in_ready && in_valid[0]) push_n = in_valid[1] ? 2'd2 : 2'd1;
  end

  always_comb begin
    pop_n = 2'd0;
    case (id_accept)
      2'b01:   pop_n = (count != '0) ? 2'd1 : 2'd0;
      2'b11:   pop_n = (count >= CW'(2)) ? 2'd2 : count[1:0];
      default: pop_n = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= '0;
        pc_q[i]  <= '0;
        pre_q[i] <= '0;
      end
    end else if (flush) begin
      // Entry contents are left stale; only the pointers are rewound.
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_n != 2'd0) begin
        ir_q[wptr]  <= in_ir0;
        pc_q[wptr]  <= in_pc0;
        pre_q[wptr] <= in_pre0;
      end
      if (push_n == 2'd2) begin
        ir_q[wptr1]  <= in_ir1;
        pc_q[wptr1]  <= in_pc1;
        pre_q[wptr1] <= in_pre1;
      end
      wptr  <= wptr + AW'(push_n);
      rptr  <= rptr + AW'(pop_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  assign IF_IR0        = ir_q[rptr];
  assign IF_IR1        = ir_q[rptr1];
  assign PC0           = pc_q[rptr];
  assign PC1           = pc_q[rptr1];
  assign brtype_pcpre0 = pre_q[rptr];
  assign brtype_pcpre1 = pre_q[rptr1];
  assign data_valid    = {count >= CW'(2), count != '0};

`ifdef IBUF_PERF_EN
  // Saturating counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cyc  <= '0;
      perf_empty_cyc <= '0;
    end else begin
      if (in_valid[0] && !in_ready && perf_full_cyc != 32'hFFFF_FFFF)
        perf_full_cyc <= perf_full_cyc + 32'd1;
      if (count == '0 && perf_empty_cyc != 32'hFFFF_FFFF)
        perf_empty_cyc <= perf_empty_cyc + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_inst_buffer.sv
// Directed self-checking bench for if_inst_buffer (DEPTH=8); perf checks only when IBUF_PERF_EN is defined.
module tb_if_inst_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [31:0] in_ir0 = '0, in_ir1 = '0, in_pc0 = '0, in_pc1 = '0;
  logic [33:0] in_pre0 = '0, in_pre1 = '0;
  logic        in_ready;
  logic [31:0] IF_IR0, IF_IR1, PC0, PC1;
  logic [33:0] brtype_pcpre0, brtype_pcpre1;
  logic [1:0]  data_valid;
  logic [1:0]  id_accept = 2'b00;
`ifdef IBUF_PERF_EN
  logic [31:0] perf_full_cyc, perf_empty_cyc;
`endif

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  if_inst_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ir0(in_ir0), .in_ir1(in_ir1), .in_pc0(in_pc0), .in_pc1(in_pc1),
    .in_pre0(in_pre0), .in_pre1(in_pre1), .in_ready(in_ready),
    .IF_IR0(IF_IR0), .IF_IR1(IF_IR1), .PC0(PC0), .PC1(PC1),
    .brtype_pcpre0(brtype_pcpre0), .brtype_pcpre1(brtype_pcpre1),
    .data_valid(data_valid),
`ifdef IBUF_PERF_EN
    .perf_full_cyc(perf_full_cyc), .perf_empty_cyc(perf_empty_cyc),
`endif
    .id_accept(id_accept)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] acc);
    in_valid  = v;
    in_ir0    = a;
    in_ir1    = b;
    in_pc0    = {a[29:0], 2'b00};
    in_pc1    = {b[29:0], 2'b00};
    in_pre0   = {2'b10, a ^ 32'hFFFF_0000};
    in_pre1   = {2'b01, b ^ 32'hFFFF_0000};
    id_accept = acc;
  endtask

  initial begin
    // reset
    step();
    step();
    chk("rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_dv", data_valid, 2'b00);
    chk("rst_ir0", IF_IR0, 0);
    chk("rst_pc0", PC0, 0);
    chk("rst_pre0", brtype_pcpre0, 0);
    chk("rst_ready1", in_ready, 1);

    // basic dual push
    drive(2'b11, 32'h0280_0421, 32'h0015_0085, 2'b00);
    in_pc0  = 32'h1c00_0000;
    in_pc1  = 32'h1c00_0004;
    in_pre0 = 34'h1_1c00_0040;
    step();
    chk("t1_dv", data_valid, 2'b11);
    chk("t1_ir0", IF_IR0, 32'h0280_0421);
    chk("t1_ir1", IF_IR1, 32'h0015_0085);
    chk("t1_pc0", PC0, 32'h1c00_0000);
    chk("t1_pc1", PC1, 32'h1c00_0004);
    chk("t1_pre0", brtype_pcpre0, 34'h1_1c00_0040);

    // fill to full
    drive(2'b11, 32'h10, 32'h11, 2'b00); step();
    drive(2'b11, 32'h20, 32'h21, 2'b00); step();
    chk("t2_ready6", in_ready, 1);
    drive(2'b11, 32'h30, 32'h31, 2'b00); step();
    chk("t2_ready8", in_ready, 0);
    drive(2'b11, 32'h40, 32'h41, 2'b00); step();
    chk("t2_ready_full", in_ready, 0);
    chk("t2_head_kept", IF_IR0, 32'h0280_0421);
    drive(2'b00, 0, 0, 2'b11); step();
    chk("t2_pop1_ir0", IF_IR0, 32'h10);
    chk("t2_pop1_ir1", IF_IR1, 32'h11);
    chk("t2_pop1_pc1", PC1, 32'h44);
    chk("t2_ready_after", in_ready, 1);
    step();
    chk("t2_pop2_ir0", IF_IR0, 32'h20);
    step();
    chk("t2_pop3_ir1", IF_IR1, 32'h31);
    step();
    chk("t2_drained", data_valid, 2'b00);

    // single push, in_valid=10, partial pop
    drive(2'b01, 32'h50, 32'h51, 2'b00); step();
    chk("t3_dv1", data_valid, 2'b01);
    chk("t3_ir0", IF_IR0, 32'h50);
    drive(2'b10, 32'h60, 32'h61, 2'b00); step();
    chk("t3_v10_nopush", data_valid, 2'b01);
    drive(2'b00, 0, 0, 2'b11); step();
    chk("t3_pop_min", data_valid, 2'b00);
    step();
    chk("t3_empty_pop", data_valid, 2'b00);
    drive(2'b01, 32'h70, 32'h71, 2'b00); step();
    chk("t3_ptr_ok", IF_IR0, 32'h70);
    chk("t3_dv_after", data_valid, 2'b01);
    drive(2'b00, 0, 0, 2'b01); step();
    chk("t3_empty", data_valid, 2'b00);

    // wrap: alternate push-11 cycles, accept 01 every cycle
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = 32'h100 + 32'(2 * i);
      b = a + 32'd1;
      if (i % 2 == 0) drive(2'b11, a, b, 2'b01);
      else            drive(2'b00, 0, 0, 2'b01);
      if (q.size() > 0) begin
        chk("t4_ir0", IF_IR0, q[0]);
        void'(q.pop_front());
      end else begin
        chk("t4_dv", data_valid, 2'b00);
      end
      if (i % 2 == 0) begin
        q.push_back(a);
        q.push_back(b);
      end
      step();
    end
    while (q.size() > 0) begin
      drive(2'b00, 0, 0, 2'b01);
      chk("t4_drain_ir0", IF_IR0, q[0]);
      void'(q.pop_front());
      step();
    end
    chk("t4_empty", data_valid, 2'b00);

    // flush beats push and pop
    drive(2'b11, 32'h200, 32'h201, 2'b00); step();
    drive(2'b11, 32'h202, 32'h203, 2'b00); step();
    drive(2'b01, 32'h204, 32'h205, 2'b00); step();
    chk("t5_head", IF_IR0, 32'h200);
    flush = 1'b1;
    drive(2'b11, 32'h2a0, 32'h2a1, 2'b11); step();
    flush = 1'b0;
    drive(2'b00, 0, 0, 2'b00);
    #1;
    chk("t5_dv", data_valid, 2'b00);
    chk("t5_ready", in_ready, 1);
    drive(2'b01, 32'h300, 32'h301, 2'b00); step();
    chk("t5_post_ir0", IF_IR0, 32'h300);
    chk("t5_post_pc0", PC0, 32'h0000_0c00);
    chk("t5_post_dv", data_valid, 2'b01);
    drive(2'b00, 0, 0, 2'b01); step();
    chk("t5_empty", data_valid, 2'b00);

`ifdef IBUF_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("p_empty4", perf_empty_cyc, 4);
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 32'h400 + 32'(i), 32'h500 + 32'(i), 2'b00);
      step();
    end
    drive(2'b01, 32'h600, 32'h601, 2'b00);
    for (int i = 0; i < 10; i++) step();
    drive(2'b00, 0, 0, 2'b00);
    #1;
    chk("p_full10", perf_full_cyc, 10);
    chk("p_empty5", perf_empty_cyc, 5);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
